// File: rtl/pipe4_pkg.sv
// Shared definitions for the 4-stage pipeline hazard controller and the pipeline top.
package pipe4_pkg;

  localparam int RA_W = 5;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MC  = 1'b1
  } state_t;

  // NOP as seen by the control path: no destination, no write.
  localparam logic [RA_W-1:0] NOP_RD  = '0;
  localparam logic            NOP_WEN = 1'b0;

endpackage

// File: rtl/pipe4_mc_counter.sv
// Loadable down-counter for multi-cycle EXE occupancy; saturates at zero.
// Load has priority over decrement; done is combinational (cnt == 0).
module pipe4_mc_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pipe4_hazard_ctrl.sv
// Hazard/sequencing control for IF-ID-EXE-WB: registered WB->EXE forwarding selects,
// front-end hold plus WB bubbles during multi-cycle EXE ops, and branch flush of IF/ID and ID/EXE.
module pipe4_hazard_ctrl #(
  parameter int RA_W   = pipe4_pkg::RA_W,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_wen,
  input  logic            id_mc,
  input  logic            exe_br_taken,
  output logic            stall_if,
  output logic            stall_id,
  output logic            hold_exe,
  output logic            bubble_wb,
  output logic            flush,
  output logic            fwd_a,
  output logic            fwd_b,
  output logic            mc_busy
);

  import pipe4_pkg::*;

  state_t            state;
  state_t            state_nxt;
  logic [RA_W-1:0]   exe_rd;
  logic              exe_wen;
  logic              advance;
  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_done;
  logic              fwd_a_nxt;
  logic              fwd_b_nxt;

  // Gated by rst so flush reads 0 while in reset even though state resets to RUN.
  assign flush   = exe_br_taken & (state == ST_RUN) & rst;
  assign advance = ~stall_id;

  pipe4_mc_counter #(
    .CNT_W (CNT_W)
  ) u_mc_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(MC_LAT - 1)),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // MC lasts MC_LAT cycles (cnt MC_LAT-1 .. 0); the final cnt==0 cycle lets the op write EXE/WB.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    hold_exe  = 1'b0;
    bubble_wb = 1'b0;
    mc_busy   = 1'b0;
    case (state)
      ST_RUN: begin
        if (id_valid && id_mc && !flush) begin
          state_nxt = ST_MC;
          cnt_load  = 1'b1;
        end
      end
      ST_MC: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        hold_exe  = 1'b1;
        mc_busy   = 1'b1;
        bubble_wb = (cnt != '0);
        cnt_dec   = 1'b1;
        if (cnt_done) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  assign fwd_a_nxt = id_valid & exe_wen & (exe_rd != '0) & (id_rs1 == exe_rd) & ~flush;
  assign fwd_b_nxt = id_valid & exe_wen & (exe_rd != '0) & (id_rs2 == exe_rd) & ~flush;

  // EXE shadow and forwarding selects move only when ID/EXE advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_rd  <= NOP_RD;
      exe_wen <= NOP_WEN;
      fwd_a   <= 1'b0;
      fwd_b   <= 1'b0;
    end else if (advance) begin
      exe_rd  <= id_rd;
      exe_wen <= flush ? NOP_WEN : (id_valid & id_wen);
      fwd_a   <= fwd_a_nxt;
      fwd_b   <= fwd_b_nxt;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && (state == ST_MC) && exe_br_taken) begin
      $error("pipe4_hazard_ctrl: exe_br_taken during multi-cycle op, ignored");
    end
  end
`endif

endmodule

// File: tb/tb_pipe4_hazard_ctrl.sv
// Directed self-checking bench for pipe4_hazard_ctrl (MC_LAT=4).
module tb_pipe4_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_wen;
  logic       id_mc;
  logic       exe_br_taken;
  logic       stall_if;
  logic       stall_id;
  logic       hold_exe;
  logic       bubble_wb;
  logic       flush;
  logic       fwd_a;
  logic       fwd_b;
  logic       mc_busy;

  int n_checks;
  int n_fail;

  pipe4_hazard_ctrl #(
    .RA_W   (5),
    .MC_LAT (4),
    .CNT_W  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_wen       (id_wen),
    .id_mc        (id_mc),
    .exe_br_taken (exe_br_taken),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .hold_exe     (hold_exe),
    .bubble_wb    (bubble_wb),
    .flush        (flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .mc_busy      (mc_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] outs();
    return {stall_if, stall_id, hold_exe, bubble_wb, flush, fwd_a, fwd_b, mc_busy};
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wen, input logic mc, input logic br);
    id_valid     = v;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_wen       = wen;
    id_mc        = mc;
    exe_br_taken = br;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] o;
    rst = 1'b1;
    idle();
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'($urandom), 1'b1);
      @(negedge clk);
      o = outs();
      n_checks++;
      if (o !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outs cyc%0d: got %b expected 00000000", i, o);
      end
      next_cycle();
    end
    rst = 1'b1;
    idle();
    @(negedge clk);
    o = outs();
    n_checks++;
    if (o !== 8'h00) begin
      n_fail++;
      $display("FAIL post_reset_outs: got %b expected 00000000", o);
    end
    next_cycle();
  endtask

  task automatic test_forward();
    // add r3 ; sub r5,r3,r3
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    next_cycle();
    set_id(1'b1, 5'd3, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++;
    if ({fwd_a, fwd_b} !== 2'b11) begin
      n_fail++;
      $display("FAIL fwd_r3: got fwd_a/b=%b%b expected 11", fwd_a, fwd_b);
    end
    next_cycle();
    // add r0 ; sub r5,r0,r0 : r0 never forwards
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++;
    if ({fwd_a, fwd_b} !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_r0: got fwd_a/b=%b%b expected 00", fwd_a, fwd_b);
    end
    next_cycle();
    // add r4 ; sub r5,r1,r4 : only operand B
    set_id(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
    next_cycle();
    set_id(1'b1, 5'd1, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++;
    if ({fwd_a, fwd_b} !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_b_only: got fwd_a/b=%b%b expected 01", fwd_a, fwd_b);
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_multicycle();
    logic [4:0] exp_stall;
    logic [4:0] exp_bub;
    idle();
    next_cycle();
    // mul r6,r1,r2 then add r7,r6,r2 waiting in ID
    set_id(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall_if !== 1'b0 || mc_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mc_cycle0: got stall_if=%b mc_busy=%b expected 0 0", stall_if, mc_busy);
    end
    next_cycle();
    set_id(1'b1, 5'd6, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
    exp_stall = 5'b01111;
    exp_bub   = 5'b00111;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({stall_if, stall_id, hold_exe, mc_busy} !== {4{exp_stall[c-1]}} ||
          bubble_wb !== exp_bub[c-1] || fwd_a !== 1'b0) begin
        n_fail++;
        $display("FAIL mc_cycle%0d: got si/sd/hx/mb=%b%b%b%b bub=%b fwd_a=%b expected %b bub=%b fwd_a=0",
                 c, stall_if, stall_id, hold_exe, mc_busy, bubble_wb, fwd_a,
                 {4{exp_stall[c-1]}}, exp_bub[c-1]);
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    n_checks++;
    if ({fwd_a, fwd_b} !== 2'b10 || stall_if !== 1'b0) begin
      n_fail++;
      $display("FAIL mc_dep_fwd: got fwd_a/b=%b%b stall_if=%b expected 10 0", fwd_a, fwd_b, stall_if);
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_branch();
    idle();
    next_cycle();
    // add r3 in EXE, then mul r6,r3,r3 in ID while branch taken
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    next_cycle();
    set_id(1'b1, 5'd3, 5'd3, 5'd6, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++;
    if (flush !== 1'b1 || stall_if !== 1'b0) begin
      n_fail++;
      $display("FAIL br_flush: got flush=%b stall_if=%b expected 1 0", flush, stall_if);
    end
    next_cycle();
    set_id(1'b1, 5'd6, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (flush !== 1'b0 || mc_busy !== 1'b0 || stall_if !== 1'b0 || {fwd_a, fwd_b} !== 2'b00) begin
      n_fail++;
      $display("FAIL br_after: got flush=%b mc_busy=%b stall_if=%b fwd=%b%b expected 0 0 0 00",
               flush, mc_busy, stall_if, fwd_a, fwd_b);
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++;
    if ({fwd_a, fwd_b} !== 2'b00 || mc_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL br_exe_wen_cleared: got fwd=%b%b mc_busy=%b expected 00 0", fwd_a, fwd_b, mc_busy);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_mc();
    idle();
    next_cycle();
    set_id(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0);
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (mc_busy !== 1'b1 || bubble_wb !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_in_mc: got mc_busy=%b bubble_wb=%b expected 1 1", mc_busy, bubble_wb);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 8'h00) begin
      n_fail++;
      $display("FAIL rmid_immediate: got %b expected 00000000", outs());
    end
    next_cycle();
    rst = 1'b1;
    set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (outs() !== 8'h00) begin
      n_fail++;
      $display("FAIL rmid_release: got %b expected 00000000", outs());
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++;
    if (stall_if !== 1'b0 || mc_busy !== 1'b0 || bubble_wb !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_flow: got stall_if=%b mc_busy=%b bubble_wb=%b expected 0 0 0",
               stall_if, mc_busy, bubble_wb);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_stall;
    logic [9:0] exp_bub;
    logic [9:0] exp_fa;
    idle();
    next_cycle();
    // mul r6,r1,r2 ; mul r10,r6,r2
    set_id(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0);
    next_cycle();
    // bit index c-1 for cycle c
    exp_stall = 10'b0111101111;
    exp_bub   = 10'b0011100111;
    exp_fa    = 10'b1111100000;
    for (int c = 1; c <= 10; c++) begin
      if (c <= 5) set_id(1'b1, 5'd6, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0);
      else        idle();
      @(negedge clk);
      n_checks++;
      if (stall_if !== exp_stall[c-1] || hold_exe !== exp_stall[c-1] ||
          bubble_wb !== exp_bub[c-1] || fwd_a !== exp_fa[c-1] || fwd_b !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got si=%b hx=%b bub=%b fa=%b fb=%b expected %b %b %b %b 0",
                 c, stall_if, hold_exe, bubble_wb, fwd_a, fwd_b,
                 exp_stall[c-1], exp_stall[c-1], exp_bub[c-1], exp_fa[c-1]);
      end
      next_cycle();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_forward();
    test_multicycle();
    test_branch();
    test_reset_mid_mc();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
